vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Downstream consumer of the pixel-rate tick from the clock divider stage.
- Generates VGA raster timing: horizontal and vertical counters, hsync/vsync, data-enable, pixel coordinates and a frame-start pulse.
- Its outputs drive the board renderer and the VGA pins.
- Runs on the system clock; it advances one pixel per cycle in which pix_en_i is high. No derived clock is used as a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- Derived localparams: H_TOTAL = sum of the H_* values (800); V_TOTAL = sum of the V_* values (525); XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
- clk_i  input  1  system clock; the single clock of the block
- rst_i  input  1  synchronous, active-high reset
- pix_en_i  input  1  pixel tick; advance one pixel when high
- hsync_o  output  1  horizontal sync, registered
- vsync_o  output  1  vertical sync, registered
- de_o  output  1  high inside the active area, registered
- x_o  output  XW  active-area column; 0 outside the active area
- y_o  output  YW  active-area row; 0 outside the active area
- frame_start_o  output  1  one-clk_i pulse when the raster wraps to (0,0)

Behaviour:
- Reset (rst_i high at a clk_i edge; rst_i has priority over pix_en_i):
  - h_cnt=0, v_cnt=0.
  - hsync_o=vsync_o=~SYNC_POL.
  - de_o=1, x_o=0, y_o=0, frame_start_o=0.
  - Position (0,0) is the first active pixel.
- Advancing:
  - On a clk_i edge with pix_en_i=1, h_cnt increments.
  - At h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=V_TOTAL-1 on that same wrap, v_cnt also wraps to 0.
  - With pix_en_i=0, all state and all outputs hold. frame_start_o is the exception: it returns to 0.
- Per-axis state machine, with regions as half-open count ranges from 0 (horizontal shown; vertical is identical, using v_cnt and V_*):
  - ACTIVE: [0, H_ACTIVE)
  - FRONT: [H_ACTIVE, H_ACTIVE+H_FRONT)
  - SYNC: [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC)
  - BACK: the remainder up to H_TOTAL-1
  - Transitions happen only on a count-advance edge: ACTIVE->FRONT->SYNC->BACK->ACTIVE.
  - Vertical state advances only on a horizontal wrap.
- Output timing:
  - All outputs are registered and updated on the same edge as the counters, so they always describe the current (h_cnt, v_cnt). There is zero latency relative to the counters.
  - de_o = (h state ACTIVE) and (v state ACTIVE).
  - x_o = h_cnt when de_o, else 0. y_o = v_cnt when de_o, else 0.
  - hsync_o = SYNC_POL while h state is SYNC, else ~SYNC_POL. vsync_o is the same, using v state.
  - vsync changes only at a line boundary, i.e. on the edge where h_cnt wraps to 0.
- frame_start_o:
  - High for exactly one clk_i cycle: the cycle after the edge that moved the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Not asserted on the reset exit.
- Back-to-back pix_en_i (tick every cycle) is legal; full rate is required.
- Reset mid-frame returns to (0,0) on the next edge with no sync glitch other than forcing the deasserted level.
- Counters never exceed TOTAL-1 under any pix_en_i pattern.
- Widths: comparisons are on XW/YW-bit unsigned values; no other arithmetic.

Decomposition:
- Shared include header vga_params.vh: default 640x480@60 timing constants (H_*/V_*), SYNC_POL default, and region encodings ACTIVE/FRONT/SYNC/BACK as 2-bit localparams.
- Sub-module vga_axis_counter:
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Ports: clk_i, rst_i, inc_i, cnt_o, region_o, wrap_o.
  - Instantiated twice: horizontal with inc_i=pix_en_i; vertical with inc_i=pix_en_i & h wrap_o.
- The top level registers de/x/y/sync/frame_start from the two instances.

Test Plan:
- Reset then pix_en_i=1 constantly -> hsync_o is first asserted (0) exactly 656 clk_i cycles after reset release, stays 0 for 96 cycles, and the period is 800 cycles.
- Full frame at full rate -> vsync_o is low for exactly 2×800=1600 cycles starting at line 490. frame_start_o pulses exactly once per 420000 cycles. The count of de_o=1 cycles per frame is 307200.
- pix_en_i high one cycle in two (25 MHz from a 50 MHz clk_i) -> all timings exactly double in clk_i cycles. Outputs hold on idle cycles. frame_start_o width stays 1 cycle.
- Scan coordinates -> at de_o=1 the last pixel of a line is x_o=639; the next tick gives de_o=0, x_o=0. The last active row is y_o=479.
- Assert rst_i for 1 cycle at h_cnt=700, v_cnt=491 (inside vsync) -> the next edge gives vsync_o=1, hsync_o=1, de_o=1, x_o=0, y_o=0, and no frame_start_o pulse.
- Random pix_en_i pattern with a reference model -> x_o/y_o/de_o/hsync_o/vsync_o/frame_start_o match every cycle for 2 frames.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared constants for the VGA raster timing generator.
//   - Default 640x480@60 timing (front porch, sync and back porch lengths for
//     each axis) and the default sync polarity (0 = active-low).
//   - Region encodings used by each axis counter's state machine.
// No ports: this package is imported by vga_axis_counter and vga_timing_gen.
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

    // Horizontal timing, in pixels
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;

    // Vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Level driven on hsync/vsync while the pulse is asserted
    localparam logic DEF_SYNC_POL = 1'b0;

    // Region encodings for the per-axis state machine
    localparam logic [1:0] REGION_ACTIVE = 2'd0;
    localparam logic [1:0] REGION_FRONT  = 2'd1;
    localparam logic [1:0] REGION_SYNC   = 2'd2;
    localparam logic [1:0] REGION_BACK   = 2'd3;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One axis (horizontal or vertical) of the raster: a wrapping position
// counter plus a four-state region machine ACTIVE->FRONT->SYNC->BACK.
//
// Ports:
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset (count 0, region ACTIVE)
//   inc_i    : advance the position by one on this edge
//   cnt_o    : position the axis will hold after this edge
//   region_o : region the axis will be in after this edge
//   wrap_o   : high when this edge takes the count from TOTAL-1 back to 0
//
// cnt_o/region_o are the next-state values rather than the registered
// ones, so the top level can register its outputs on the same edge as the
// counters and have them describe the current position with no lag.
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int W      = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic [1:0]   region_o,
    output logic         wrap_o
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    // Last count of each region; a region is left on the edge that
    // advances from its last count.
    localparam logic [W-1:0] ACTIVE_LAST = W'(ACTIVE - 1);
    localparam logic [W-1:0] FRONT_LAST  = W'(ACTIVE + FRONT - 1);
    localparam logic [W-1:0] SYNC_LAST   = W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [W-1:0] TOTAL_LAST  = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [1:0]   region_q;
    logic [W-1:0] cnt_next;
    logic [1:0]   region_next;
    logic         wrap;

    // Next-state logic. Nothing moves unless inc_i is high. The wrap case
    // is handled first so the count can never run past TOTAL-1, and it
    // always lands back in ACTIVE regardless of the region we came from.
    always_comb begin
        cnt_next    = cnt_q;
        region_next = region_q;
        wrap        = 1'b0;
        if (inc_i) begin
            if (cnt_q == TOTAL_LAST) begin
                cnt_next    = '0;
                region_next = REGION_ACTIVE;
                wrap        = 1'b1;
            end else begin
                cnt_next = cnt_q + W'(1);
                case (region_q)
                    REGION_ACTIVE: if (cnt_q == ACTIVE_LAST) region_next = REGION_FRONT;
                    REGION_FRONT:  if (cnt_q == FRONT_LAST)  region_next = REGION_SYNC;
                    REGION_SYNC:   if (cnt_q == SYNC_LAST)   region_next = REGION_BACK;
                    default:       region_next = region_q;
                endcase
            end
        end
    end

    // State register. Reset puts the axis at position 0, which is the
    // first pixel/line of the active area.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            region_q <= REGION_ACTIVE;
        end else begin
            cnt_q    <= cnt_next;
            region_q <= region_next;
        end
    end

    assign cnt_o    = cnt_next;
    assign region_o = region_next;
    assign wrap_o   = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator running on the system clock. The raster
// advances one pixel on each clk_i edge where pix_en_i is high.
//
// Ports:
//   clk_i         : system clock, the only clock of the block
//   rst_i         : synchronous active-high reset, wins over pix_en_i
//   pix_en_i      : pixel tick; advance one pixel when high
//   hsync_o       : registered horizontal sync (SYNC_POL while asserted)
//   vsync_o       : registered vertical sync (SYNC_POL while asserted)
//   de_o          : registered data enable, high inside the active area
//   x_o           : active-area column, 0 outside the active area
//   y_o           : active-area row, 0 outside the active area
//   frame_start_o : one-cycle pulse after the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = DEF_SYNC_POL,
    localparam int  H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int  V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int  XW       = $clog2(H_TOTAL),
    localparam int  YW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pix_en_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          frame_start_o
);

    logic [XW-1:0] h_cnt_next;
    logic [1:0]    h_region_next;
    logic          h_wrap;
    logic [YW-1:0] v_cnt_next;
    logic [1:0]    v_region_next;
    logic          v_wrap;
    logic          v_inc;
    logic          active_next;

    // The vertical axis only steps on the edge that finishes a line, which
    // also means vsync can only change on a line boundary.
    assign v_inc = pix_en_i & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (XW)
    ) u_h_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (pix_en_i),
        .cnt_o    (h_cnt_next),
        .region_o (h_region_next),
        .wrap_o   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (YW)
    ) u_v_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (v_inc),
        .cnt_o    (v_cnt_next),
        .region_o (v_region_next),
        .wrap_o   (v_wrap)
    );

    // The pixel is visible only when both axes sit in their active regions.
    always_comb begin
        active_next = (h_region_next == REGION_ACTIVE) &&
                      (v_region_next == REGION_ACTIVE);
    end

    // Output registers. They are fed from the counters' next-state values,
    // so after each edge they describe the position the counters just moved
    // to. On idle cycles the next-state values equal the current ones and
    // everything holds, except frame_start which is only high on the edge
    // that performs the full-frame wrap. Reset forces the deasserted sync
    // level and the (0,0) active pixel, with no frame_start pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            de_o          <= 1'b1;
            x_o           <= '0;
            y_o           <= '0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= (h_region_next == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= (v_region_next == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
            de_o          <= active_next;
            x_o           <= active_next ? h_cnt_next : '0;
            y_o           <= active_next ? v_cnt_next : '0;
            frame_start_o <= h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock, reset and pixel tick:
//   dut_full  : default 640x480 timing, active-low syncs
//   dut_small : reduced raster (H 8/2/3/3 = 16, V 6/1/2/3 = 12, 192 pixels
//               per frame) with active-high syncs, so whole frames, half-rate
//               operation, mid-frame reset and a random tick pattern fit in a
//               short run.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic pix_en;

    logic       f_hsync, f_vsync, f_de, f_fs;
    logic [9:0] f_x, f_y;

    logic       s_hsync, s_vsync, s_de, s_fs;
    logic [3:0] s_x, s_y;

    int compared;
    int mismatched;

    vga_timing_gen dut_full (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_en_i      (pix_en),
        .hsync_o       (f_hsync),
        .vsync_o       (f_vsync),
        .de_o          (f_de),
        .x_o           (f_x),
        .y_o           (f_y),
        .frame_start_o (f_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (3),
        .V_ACTIVE (6),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (3),
        .SYNC_POL (1'b1)
    ) dut_small (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_en_i      (pix_en),
        .hsync_o       (s_hsync),
        .vsync_o       (s_vsync),
        .de_o          (s_de),
        .x_o           (s_x),
        .y_o           (s_y),
        .frame_start_o (s_fs)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive reset and tick for one edge, then return 1 time unit after the
    // edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic r, input logic e);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        #1;
    endtask

    // One counted comparison; failures are reported and counted.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int   fall1, rise1, fall2, vs_bad;
        int   vs_rise, vs_fall, fs_count, fs_at, de_count, hs_count, max_x, max_y;
        int   hold_bad, hs_rise;
        int   mh, mv, frames;
        logic prev_hs, prev_vs;
        logic p_hs, p_vs, p_de;
        logic [3:0] p_x, p_y;
        logic en, e_de, e_hs, e_vs, e_fs;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        pix_en     = 1'b0;

        // ---- Reset state of both instances ----
        applyStimulus(1'b1, 1'b0);
        checkOutput("full_rst_hsync", f_hsync, 1);
        checkOutput("full_rst_vsync", f_vsync, 1);
        checkOutput("full_rst_de",    f_de,    1);
        checkOutput("full_rst_x",     f_x,     0);
        checkOutput("full_rst_y",     f_y,     0);
        checkOutput("full_rst_fs",    f_fs,    0);
        checkOutput("small_rst_hsync", s_hsync, 0);
        checkOutput("small_rst_vsync", s_vsync, 0);

        // ---- Default timing at full rate: hsync position/width/period ----
        $display("[TB] default timing, full rate");
        fall1 = -1; rise1 = -1; fall2 = -1; vs_bad = 0; prev_hs = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (f_hsync == 1'b0 && prev_hs == 1'b1) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (f_hsync == 1'b1 && prev_hs == 1'b0 && rise1 < 0) rise1 = k;
            if (k == 639) begin
                checkOutput("full_last_x",  f_x,  639);
                checkOutput("full_last_de", f_de, 1);
            end
            if (k == 640) begin
                checkOutput("full_porch_de", f_de, 0);
                checkOutput("full_porch_x",  f_x,  0);
            end
            if (k == 800) begin
                checkOutput("full_line1_y",  f_y,  1);
                checkOutput("full_line1_x",  f_x,  0);
                checkOutput("full_line1_de", f_de, 1);
            end
            if (f_vsync !== 1'b1) vs_bad++;
            prev_hs = f_hsync;
        end
        checkOutput("full_hsync_start",  fall1,         656);
        checkOutput("full_hsync_width",  rise1 - fall1, 96);
        checkOutput("full_hsync_period", fall2 - fall1, 800);
        checkOutput("full_vsync_idle",   vs_bad,        0);

        // ---- Small raster, one full frame at full rate ----
        $display("[TB] small raster, full rate");
        applyStimulus(1'b1, 1'b0);
        vs_rise = -1; vs_fall = -1; fs_count = 0; fs_at = -1;
        de_count = 0; hs_count = 0; max_x = 0; max_y = 0; prev_vs = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (s_vsync == 1'b1 && prev_vs == 1'b0 && vs_rise < 0) vs_rise = k;
            if (s_vsync == 1'b0 && prev_vs == 1'b1 && vs_fall < 0) vs_fall = k;
            if (s_fs) begin
                fs_count++;
                fs_at = k;
            end
            if (k <= 192) begin
                if (s_de) de_count++;
                if (s_hsync) hs_count++;
            end
            if (s_de && int'(s_x) > max_x) max_x = int'(s_x);
            if (s_de && int'(s_y) > max_y) max_y = int'(s_y);
            prev_vs = s_vsync;
        end
        checkOutput("small_vsync_start", vs_rise,           112);
        checkOutput("small_vsync_width", vs_fall - vs_rise, 32);
        checkOutput("small_fs_count",    fs_count,          1);
        checkOutput("small_fs_at",       fs_at,             192);
        checkOutput("small_de_count",    de_count,          48);
        checkOutput("small_hs_count",    hs_count,          36);
        checkOutput("small_max_x",       max_x,             7);
        checkOutput("small_max_y",       max_y,             5);

        // ---- Small raster, tick every other cycle ----
        $display("[TB] small raster, half rate");
        applyStimulus(1'b1, 1'b0);
        hold_bad = 0; hs_rise = -1; vs_rise = -1; fs_count = 0; fs_at = -1;
        p_hs = s_hsync; p_vs = s_vsync; p_de = s_de; p_x = s_x; p_y = s_y;
        for (int n = 1; n <= 400; n++) begin
            en = (n % 2) == 1;
            applyStimulus(1'b0, en);
            if (!en) begin
                if (s_hsync !== p_hs || s_vsync !== p_vs || s_de !== p_de ||
                    s_x !== p_x || s_y !== p_y || s_fs !== 1'b0)
                    hold_bad++;
            end
            if (s_hsync == 1'b1 && p_hs == 1'b0 && hs_rise < 0) hs_rise = n;
            if (s_vsync == 1'b1 && p_vs == 1'b0 && vs_rise < 0) vs_rise = n;
            if (s_fs) begin
                fs_count++;
                fs_at = n;
            end
            p_hs = s_hsync; p_vs = s_vsync; p_de = s_de; p_x = s_x; p_y = s_y;
        end
        checkOutput("half_hold",        hold_bad, 0);
        checkOutput("half_hsync_start", hs_rise,  19);
        checkOutput("half_vsync_start", vs_rise,  223);
        checkOutput("half_fs_count",    fs_count, 1);
        checkOutput("half_fs_at",       fs_at,    383);

        // ---- Mid-frame reset inside both sync pulses (h=11, v=8) ----
        $display("[TB] reset inside sync");
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 139; k++) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_pre_hsync", s_hsync, 1);
        checkOutput("mid_pre_vsync", s_vsync, 1);
        checkOutput("mid_pre_de",    s_de,    0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_rst_hsync", s_hsync, 0);
        checkOutput("mid_rst_vsync", s_vsync, 0);
        checkOutput("mid_rst_de",    s_de,    1);
        checkOutput("mid_rst_x",     s_x,     0);
        checkOutput("mid_rst_y",     s_y,     0);
        checkOutput("mid_rst_fs",    s_fs,    0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid_after_x",  s_x,  1);
        checkOutput("mid_after_y",  s_y,  0);
        checkOutput("mid_after_fs", s_fs, 0);

        // ---- Random tick pattern against a position model, two frames ----
        $display("[TB] small raster, random tick");
        applyStimulus(1'b1, 1'b0);
        mh = 0; mv = 0; frames = 0;
        for (int n = 0; n < 3000 && frames < 2; n++) begin
            en = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, en);
            e_fs = 1'b0;
            if (en) begin
                if (mh == 15 && mv == 11) e_fs = 1'b1;
                mh++;
                if (mh == 16) begin
                    mh = 0;
                    mv++;
                    if (mv == 12) mv = 0;
                end
            end
            if (e_fs) frames++;
            e_de = (mh < 8) && (mv < 6);
            e_hs = (mh >= 10) && (mh < 13);
            e_vs = (mv >= 7) && (mv < 9);
            checkOutput("rand_de",    s_de,    e_de);
            checkOutput("rand_x",     s_x,     e_de ? mh : 0);
            checkOutput("rand_y",     s_y,     e_de ? mv : 0);
            checkOutput("rand_hsync", s_hsync, e_hs);
            checkOutput("rand_vsync", s_vsync, e_vs);
            checkOutput("rand_fs",    s_fs,    e_fs);
        end
        checkOutput("rand_frames", frames, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
